// File: rtl/fft_config_ctrl.sv
// fft_config_ctrl: single-beat AXI-Stream master for the FFT core config port.
// Each commit snapshots nfft/forward/scale_sch into a packed word. One more
// commit can wait in a shadow register behind the beat in flight. A commit
// made while the shadow is already full replaces the shadowed word and bumps
// drop_count.
module fft_config_ctrl #(
  parameter int NUM_CHANNELS    = 1,
  parameter int SCALE_SCH_WIDTH = 4,
  parameter int NFFT_WIDTH      = 5,
  parameter int CONFIG_WIDTH    = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic [NUM_CHANNELS*SCALE_SCH_WIDTH-1:0] scale_sch,
  input  logic [NUM_CHANNELS-1:0]                 forward,
  input  logic [NFFT_WIDTH-1:0]                   nfft,
  input  logic                                    commit,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tvalid,
  output logic                                    m_axis_tlast,
  output logic [CONFIG_WIDTH-1:0]                 m_axis_tdata,
  output logic                                    busy,
  output logic                                    done,
  output logic [COUNT_WIDTH-1:0]                  sent_count,
  output logic [COUNT_WIDTH-1:0]                  drop_count
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int SCH_LSB = NFFT_WIDTH + NUM_CHANNELS;

  state_t                  state_q, state_n;
  logic [CONFIG_WIDTH-1:0] data_q, data_n;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_n;
  logic                    pending_q, pending_n;
  logic                    done_q;
  logic [COUNT_WIDTH-1:0]  sent_q, drop_q;
  logic [CONFIG_WIDTH-1:0] snap;
  logic                    hs;
  logic                    drop_inc;

  // Pack the live inputs LSB first: nfft, forward bits, scale schedules, zero pad
  always_comb begin
    snap = '0;
    snap[NFFT_WIDTH-1:0]                             = nfft;
    snap[NFFT_WIDTH +: NUM_CHANNELS]                 = forward;
    snap[SCH_LSB +: NUM_CHANNELS*SCALE_SCH_WIDTH]    = scale_sch;
  end

  assign hs = (state_q == SEND) && m_axis_tready;

  // Next-state: launch, hold under backpressure, chain the shadow word, queue or drop commits
  always_comb begin
    state_n   = state_q;
    data_n    = data_q;
    shadow_n  = shadow_q;
    pending_n = pending_q;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_n = SEND;
          data_n  = snap;
        end
      end
      SEND: begin
        if (hs) begin
          if (pending_q) begin
            // Shadow word goes out with no bubble; a same-cycle commit takes its slot
            data_n    = shadow_q;
            pending_n = commit;
            if (commit) shadow_n = snap;
          end else if (commit) begin
            data_n = snap;              // back-to-back beat, nothing was queued
          end else begin
            state_n = IDLE;
          end
        end else if (commit) begin
          shadow_n  = snap;             // last commit wins
          pending_n = 1'b1;
          drop_inc  = pending_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, data and counter registers; async reset abandons any beat in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      data_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      shadow_q  <= shadow_n;
      pending_q <= pending_n;
      done_q    <= hs;
      sent_q    <= sent_q + {{(COUNT_WIDTH-1){1'b0}}, hs};
      if (drop_inc && (drop_q != {COUNT_WIDTH{1'b1}}))
        drop_q <= drop_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = m_axis_tvalid;
  assign m_axis_tdata  = data_q;
  assign busy          = m_axis_tvalid | pending_q;
  assign done          = done_q;
  assign sent_count    = sent_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_fft_config_ctrl.sv
// Bench for fft_config_ctrl: directed scenarios plus random traffic, checked
// against a queue model of the words that have been committed but not yet sent.
module tb_fft_config_ctrl;
  localparam int NC = 2, SW = 4, NW = 5, CW = 16, CNT = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NC*SW-1:0] scale_sch;
  logic [NC-1:0] forward;
  logic [NW-1:0] nfft;
  logic          commit;
  logic          m_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, busy, done;
  logic [CW-1:0] m_axis_tdata;
  logic [CNT-1:0] sent_count, drop_count;
  // second instance with tiny counters to reach wrap / saturation quickly
  logic          s_tvalid, s_tlast, s_busy, s_done;
  logic [CW-1:0] s_tdata;
  logic [1:0]    s_sent, s_drop;

  fft_config_ctrl #(.NUM_CHANNELS(NC), .SCALE_SCH_WIDTH(SW), .NFFT_WIDTH(NW),
                    .CONFIG_WIDTH(CW), .COUNT_WIDTH(CNT)) dut (
    .clk(clk), .resetn(resetn), .scale_sch(scale_sch), .forward(forward), .nfft(nfft),
    .commit(commit), .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata), .busy(busy), .done(done),
    .sent_count(sent_count), .drop_count(drop_count));

  fft_config_ctrl #(.NUM_CHANNELS(NC), .SCALE_SCH_WIDTH(SW), .NFFT_WIDTH(NW),
                    .CONFIG_WIDTH(CW), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .scale_sch(scale_sch), .forward(forward), .nfft(nfft),
    .commit(commit), .m_axis_tready(m_axis_tready), .m_axis_tvalid(s_tvalid),
    .m_axis_tlast(s_tlast), .m_axis_tdata(s_tdata), .busy(s_busy), .done(s_done),
    .sent_count(s_sent), .drop_count(s_drop));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: q[0] is the beat on the bus, q[1] (if any) is queued
  logic [CW-1:0] q[$];
  int  m_sent = 0, m_drop = 0;
  bit  m_done = 0;

  function automatic logic [CW-1:0] pack(input logic [NC*SW-1:0] s, input logic [NC-1:0] f,
                                         input logic [NW-1:0] n);
    int unsigned v;
    v = int'(n) + (int'(f) * 32) + (int'(s) * 128);
    return v[CW-1:0];
  endfunction

  function automatic logic [35:0] exp_ctl();
    logic v;
    logic [15:0] sc, dc;
    v  = (q.size() > 0);
    sc = m_sent[15:0];
    dc = (m_drop > 65535) ? 16'hFFFF : m_drop[15:0];
    return {v, v, v, m_done, sc, dc};
  endfunction

  function automatic logic [3:0] exp_sat();
    logic [1:0] sc, dc;
    sc = m_sent[1:0];
    dc = (m_drop > 3) ? 2'd3 : m_drop[1:0];
    return {sc, dc};
  endfunction

  // One clock: model follows the same input values the DUT sampled, then settle to negedge
  task automatic tick();
    bit hs;
    @(posedge clk);
    if (!resetn) begin
      q.delete(); m_sent = 0; m_drop = 0; m_done = 0;
    end else begin
      hs = (q.size() > 0) && m_axis_tready;
      m_done = hs;
      if (hs) begin void'(q.pop_front()); m_sent++; end
      if (commit) begin
        q.push_back(pack(scale_sch, forward, nfft));
        if (q.size() > 2) begin q.delete(1); m_drop++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    scale_sch = 8'($urandom); forward = 2'($urandom); nfft = 5'($urandom);
  endtask

  task automatic test_reset();
    logic [35:0] act;
    resetn = 1'b0; commit = 1'b0; m_axis_tready = 1'b1;
    scale_sch = '0; forward = '0; nfft = '0;
    tick(); tick();
    act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
    total++;
    if (act !== exp_ctl()) begin bad++; $display("FAIL reset_ctl got=%h want=%h", act, exp_ctl()); end
    total++;
    if (m_axis_tdata !== 16'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [35:0] act;
    scale_sch = 8'hA5; forward = 2'b10; nfft = 5'd10; m_axis_tready = 1'b1; commit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      commit = 1'b0;
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL single_ctl c%0d got=%h want=%h", i, act, exp_ctl()); end
      if (q.size() > 0) begin
        total++;
        if (m_axis_tdata !== q[0]) begin bad++; $display("FAIL single_data got=%h want=%h", m_axis_tdata, q[0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] act;
    logic [CW-1:0] first;
    rand_inputs(); first = pack(scale_sch, forward, nfft);
    m_axis_tready = 1'b0; commit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      commit = 1'b0;
      rand_inputs();
      m_axis_tready = (i == 5);
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL bp_ctl c%0d got=%h want=%h", i, act, exp_ctl()); end
      if (m_axis_tvalid) begin
        total++;
        if (m_axis_tdata !== first) begin bad++; $display("FAIL bp_data c%0d got=%h want=%h", i, m_axis_tdata, first); end
      end
    end
  endtask

  // commits: in-flight word then a table of nfft values while stalled; drains afterwards
  task automatic test_queued(input string name, input int ncommit);
    logic [35:0] act;
    logic [3:0]  sact;
    m_axis_tready = 1'b0;
    for (int i = 0; i < ncommit + 6; i++) begin
      rand_inputs();
      commit = (i < ncommit);
      if (i > 0 && i < ncommit) nfft = 5'(i);
      m_axis_tready = (i >= ncommit + 1);
      tick();
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL %s_ctl c%0d got=%h want=%h", name, i, act, exp_ctl()); end
      if (q.size() > 0) begin
        total++;
        if (m_axis_tdata !== q[0]) begin bad++; $display("FAIL %s_data c%0d got=%h want=%h", name, i, m_axis_tdata, q[0]); end
      end
      sact = {s_sent, s_drop};
      total++;
      if (sact !== exp_sat()) begin bad++; $display("FAIL %s_sat got=%h want=%h", name, sact, exp_sat()); end
    end
    commit = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [35:0] act;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      commit = (i < 3);
      tick();
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL b2b_ctl c%0d got=%h want=%h", i, act, exp_ctl()); end
      if (q.size() > 0) begin
        total++;
        if (m_axis_tdata !== q[0]) begin bad++; $display("FAIL b2b_data c%0d got=%h want=%h", i, m_axis_tdata, q[0]); end
      end
    end
    commit = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [35:0] act;
    m_axis_tready = 1'b0; commit = 1'b1;
    rand_inputs(); tick();
    rand_inputs(); tick();
    commit = 1'b0;
    #2 resetn = 1'b0;
    #1;
    q.delete(); m_sent = 0; m_drop = 0; m_done = 0;
    act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
    total++;
    if (act !== 36'h0) begin bad++; $display("FAIL rstmid_async got=%h want=0", act); end
    tick();
    resetn = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      tick();
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL rstmid_idle c%0d got=%h want=%h", i, act, exp_ctl()); end
    end
  endtask

  task automatic test_random();
    logic [35:0] act;
    logic [3:0]  sact;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      commit = ($urandom_range(0, 99) < 35);
      m_axis_tready = ($urandom_range(0, 99) < 45);
      tick();
      act = {m_axis_tvalid, m_axis_tlast, busy, done, sent_count, drop_count};
      total++;
      if (act !== exp_ctl()) begin bad++; $display("FAIL rand_ctl c%0d got=%h want=%h", i, act, exp_ctl()); end
      if (q.size() > 0) begin
        total++;
        if (m_axis_tdata !== q[0]) begin bad++; $display("FAIL rand_data c%0d got=%h want=%h", i, m_axis_tdata, q[0]); end
      end
      sact = {s_sent, s_drop};
      total++;
      if (sact !== exp_sat()) begin bad++; $display("FAIL rand_sat c%0d got=%h want=%h", i, sact, exp_sat()); end
    end
    commit = 1'b0; m_axis_tready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_queued("queued", 2);
    test_queued("overrun", 4);
    test_queued("saturate", 8);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
